// File: rtl/lsu_bus_adapter.sv
// RV32I load/store unit: lane steering, sign/zero extension and a req/ready
// data-bus handshake that stalls the single-cycle core until the access commits.
module lsu_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic [1:0]  exc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {EXC_NONE, EXC_MISALIGN, EXC_BUS, EXC_TIMEOUT} exc_e;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  exc_e        exc_q, exc_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_q, load_d;

  logic        access, legal, aligned;
  logic [3:0]  steer_wstrb;
  logic [31:0] steer_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Request decode; a simultaneous read and write enable is treated as a load.
  always_comb begin
    access = mem_read_en | mem_write_en;
    if (mem_read_en)
      legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      legal = funct3 inside {3'b000, 3'b001, 3'b010};
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    case (funct3[1:0])
      2'b00: begin
        steer_wdata = {4{store_data[7:0]}};
        steer_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        steer_wdata = {2{store_data[15:0]}};
        steer_wstrb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        steer_wdata = store_data;
        steer_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rd_byte = 8'(bus_rdata >> {lane_q, 3'b000});
    rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'h0, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_ext = {16'h0, rd_half};
      default: rd_ext = bus_rdata;
    endcase
  end

  // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    exc_d     = exc_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    stall     = 1'b0;
    exc       = EXC_NONE;
    load_data = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (legal && aligned) begin
            stall   = 1'b1;
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = mem_write_en & ~mem_read_en;
            addr_d  = {addr[31:2], 2'b00};
            wstrb_d = mem_read_en ? 4'b0000 : steer_wstrb;
            wdata_d = steer_wdata;
            f3_d    = funct3;
            lane_d  = addr[1:0];
            cnt_d   = '0;
          end else begin
            exc = EXC_MISALIGN;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (bus_err) begin
            load_d = '0;
            exc_d  = EXC_BUS;
          end else begin
            load_d = we_q ? 32'h0 : rd_ext;
            exc_d  = EXC_NONE;
          end
        end else if (cnt_q == LAST_CNT) begin
          req_d   = 1'b0;
          state_d = DONE;
          load_d  = '0;
          exc_d   = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        load_data = load_q;
        exc       = exc_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      exc_q   <= EXC_NONE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Scoreboard bench for lsu_bus_adapter: stimulus queues expected bus requests
// and commit results; a negedge monitor compares them as the DUT presents them.
module tb_lsu_bus_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall;
  logic [1:0]  exc;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready, bus_err;
  logic [31:0] bus_rdata;

  lsu_bus_adapter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .stall(stall), .exc(exc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          chk_wdata;
  } bus_exp_t;

  typedef struct {
    logic [1:0]  exc;
    logic [31:0] ld;
    int          stall_cyc;
    int          req_cyc;
    bit          chk_wstrb;
    logic [3:0]  wstrb;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req)
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    else
      n_pass++;
  endtask

  // Bus slave model: ready after resp_waits request cycles (-1 = never).
  int          resp_waits = 0;
  logic        resp_err   = 1'b0;
  logic [31:0] resp_rdata = '0;
  int          rcnt = 0;

  initial begin
    bus_ready = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = '0;
  end

  always @(posedge clk) begin
    #2;
    if (bus_req) begin
      bus_ready = (resp_waits >= 0) && (rcnt == resp_waits);
      bus_err   = bus_ready & resp_err;
      bus_rdata = bus_ready ? resp_rdata : 32'h0;
      rcnt++;
    end else begin
      bus_ready = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = '0;
      rcnt      = 0;
    end
  end

  // Monitor
  int   stall_cnt = 0;
  int   req_cnt   = 0;
  logic prev_req  = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      stall_cnt = 0;
      req_cnt   = 0;
      prev_req  = 1'b0;
    end else begin
      if (stall) stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        if (!prev_req) begin
          check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
          if (bus_q.size() != 0) begin
            bus_exp_t b;
            b = bus_q.pop_front();
            check("bus_we", 32'(bus_we), 32'(b.we));
            check("bus_addr", bus_addr, b.addr);
            check("bus_wstrb", 32'(bus_wstrb), 32'(b.wstrb));
            if (b.chk_wdata) check("bus_wdata", bus_wdata, b.wdata);
          end
        end
      end
      prev_req = bus_req;
      if (!stall && (mem_read_en || mem_write_en)) begin
        check("commit_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          check("exc", 32'(exc), 32'(r.exc));
          check("load_data", load_data, r.ld);
          check("stall_cycles", 32'(stall_cnt), 32'(r.stall_cyc));
          check("req_cycles", 32'(req_cnt), 32'(r.req_cyc));
          if (r.chk_wstrb) check("wstrb_held", 32'(bus_wstrb), 32'(r.wstrb));
        end
        stall_cnt = 0;
        req_cnt   = 0;
      end
    end
  end

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] ws,
                          input logic [31:0] wd, input bit chk);
    bus_exp_t b;
    b.we = we; b.addr = a; b.wstrb = ws; b.wdata = wd; b.chk_wdata = chk;
    bus_q.push_back(b);
  endtask

  task automatic push_rsp(input logic [1:0] e, input logic [31:0] ld, input int sc,
                          input int rc, input bit cw, input logic [3:0] ws);
    rsp_exp_t r;
    r.exc = e; r.ld = ld; r.stall_cyc = sc; r.req_cyc = rc; r.chk_wstrb = cw; r.wstrb = ws;
    rsp_q.push_back(r);
  endtask

  // Present one instruction and hold it until the cycle in which it commits.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input int waits,
                           input logic err, input logic [31:0] rdata, input string tag);
    bit done;
    resp_waits   = waits;
    resp_err     = err;
    resp_rdata   = rdata;
    mem_read_en  = rd;
    mem_write_en = wr;
    funct3       = f3;
    addr         = a;
    store_data   = sd;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    check({tag, "_commit_bound"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    mem_read_en = 1'b0; mem_write_en = 1'b0;
    funct3 = '0; addr = '0; store_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);

    // SW, zero wait states
    push_bus(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1);
    push_rsp(2'b00, 32'h0, 2, 1, 1'b0, 4'h0);
    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1'b0, 32'h0, "sw");

    // SB to lane 3
    push_bus(1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1'b1);
    push_rsp(2'b00, 32'h0, 2, 1, 1'b0, 4'h0);
    do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 1'b0, 32'h0, "sb");

    // LB / LBU lane 3, LB lane 1 positive
    push_bus(1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b00, 32'hFFFFFF80, 2, 1, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b0, 32'h80000000, "lb");
    push_bus(1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b00, 32'h00000080, 2, 1, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b0, 32'h80000000, "lbu");
    push_bus(1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b00, 32'h0000007F, 2, 1, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 0, 1'b0, 32'h00007F00, "lb_lane1");

    // LH upper half with 3 wait states, LHU lower half
    push_bus(1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b00, 32'hFFFF8001, 5, 4, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 3, 1'b0, 32'h80011234, "lh");
    push_bus(1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b00, 32'h00001234, 2, 1, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 0, 1'b0, 32'h80011234, "lhu");

    // Misaligned LW
    push_rsp(2'b01, 32'h0, 0, 0, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 1'b0, 32'h0, "lw_misal");

    // SH upper half, then misaligned SH and illegal store leave wstrb untouched
    push_bus(1'b1, 32'h200, 4'b1100, 32'hBEEFBEEF, 1'b1);
    push_rsp(2'b00, 32'h0, 2, 1, 1'b0, 4'h0);
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 0, 1'b0, 32'h0, "sh");
    push_rsp(2'b01, 32'h0, 0, 0, 1'b1, 4'b1100);
    do_access(1'b0, 1'b1, 3'b001, 32'h205, 32'h00001111, 0, 1'b0, 32'h0, "sh_misal");
    push_rsp(2'b01, 32'h0, 0, 0, 1'b1, 4'b1100);
    do_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 1'b0, 32'h0, "st_illegal");
    push_rsp(2'b01, 32'h0, 0, 0, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b0, 32'h0, "ld_illegal");

    // Both enables: load wins
    push_bus(1'b0, 32'h300, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b00, 32'h12345678, 2, 1, 1'b0, 4'h0);
    do_access(1'b1, 1'b1, 3'b010, 32'h300, 32'hFFFFFFFF, 0, 1'b0, 32'h12345678, "rd_wr");

    // Timeout and bus error
    push_bus(1'b0, 32'h104, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b11, 32'h0, 17, 16, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, -1, 1'b0, 32'h0, "lw_timeout");
    push_bus(1'b0, 32'h108, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b10, 32'h0, 2, 1, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 0, 1'b1, 32'hFFFFFFFF, "lw_err");

    // Reset during the second BUSY cycle abandons the access
    push_bus(1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    resp_waits = 5; resp_err = 1'b0; resp_rdata = 32'h55555555;
    mem_read_en = 1'b1; funct3 = 3'b010; addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    mem_read_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_bus_req", 32'(bus_req), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_exc", 32'(exc), 32'd0);

    push_bus(1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
    push_rsp(2'b00, 32'hAABBCCDD, 2, 1, 1'b0, 4'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, 32'hAABBCCDD, "lw_after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(bus_q.size() + rsp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
